hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage core (IF, ID, EX, DM, WB).
- Tracks destination registers of in-flight instructions and generates the registered bypass selects (byp0_EX, byp0_DM, byp1_EX, byp1_DM) consumed by the EX-stage source muxes.
- Generates per-stage stall and bubble controls for load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
- Includes a data-memory wait watchdog.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: bypass selects, load-use/flush/mem-wait stalls, dm watchdog.
// Optional perf counters built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int RA_W       = 4,
  parameter int DM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_p0_addr,
  input  logic [RA_W-1:0] id_p1_addr,
  input  logic            id_re0,
  input  logic            id_re1,
  input  logic [RA_W-1:0] id_dst_addr,
  input  logic            id_we_rf,
  input  logic            id_mem_rd,
  input  logic            br_flush,
  input  logic            dm_busy,
  output logic            byp0_EX,
  output logic            byp0_DM,
  output logic            byp1_EX,
  output logic            byp1_DM,
  output logic            stall_IF_ID,
  output logic            stall_ID_EX,
  output logic            stall_EX_DM,
  output logic            stall_DM_WB,
  output logic            bubble_ID_EX,
  output logic            flush_IF_ID,
  output logic            dm_err,
  output logic [15:0]     ldu_cnt,
  output logic [15:0]     mem_cnt
);
  // Counter must be able to reach DM_TIMEOUT+1 to detect the overrun.
  localparam int CW = $clog2(DM_TIMEOUT + 2);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} wd_state_t;

  logic [RA_W-1:0] dst_idex, dst_exdm;
  logic            we_idex, ld_idex, we_exdm;
  logic            hit_ex0, hit_ex1, hit_dm0, hit_dm1, ldu;

  assign hit_ex0 = id_re0 && we_idex && (dst_idex == id_p0_addr) && (dst_idex != '0);
  assign hit_ex1 = id_re1 && we_idex && (dst_idex == id_p1_addr) && (dst_idex != '0);
  assign hit_dm0 = id_re0 && we_exdm && (dst_exdm == id_p0_addr) && (dst_exdm != '0);
  assign hit_dm1 = id_re1 && we_exdm && (dst_exdm == id_p1_addr) && (dst_exdm != '0);
  assign ldu     = ld_idex && (hit_ex0 || hit_ex1);

  always_comb begin
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    stall_DM_WB  = 1'b0;
    bubble_ID_EX = 1'b0;
    flush_IF_ID  = 1'b0;
    if (dm_busy) begin
      stall_IF_ID = 1'b1;
      stall_ID_EX = 1'b1;
      stall_EX_DM = 1'b1;
      stall_DM_WB = 1'b1;
    end else if (br_flush) begin
      flush_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end else if (ldu) begin
      stall_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end
  end

  // Tracking and bypass selects all freeze while data memory is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_idex <= '0;
      we_idex  <= 1'b0;
      ld_idex  <= 1'b0;
      dst_exdm <= '0;
      we_exdm  <= 1'b0;
      byp0_EX  <= 1'b0;
      byp0_DM  <= 1'b0;
      byp1_EX  <= 1'b0;
      byp1_DM  <= 1'b0;
    end else if (!dm_busy) begin
      dst_exdm <= dst_idex;
      we_exdm  <= we_idex;
      if (bubble_ID_EX) begin
        dst_idex <= '0;
        we_idex  <= 1'b0;
        ld_idex  <= 1'b0;
        byp0_EX  <= 1'b0;
        byp0_DM  <= 1'b0;
        byp1_EX  <= 1'b0;
        byp1_DM  <= 1'b0;
      end else begin
        dst_idex <= id_dst_addr;
        we_idex  <= id_we_rf;
        ld_idex  <= id_mem_rd;
        byp0_EX  <= hit_ex0;
        byp0_DM  <= hit_dm0 && !hit_ex0;
        byp1_EX  <= hit_ex1;
        byp1_DM  <= hit_dm1 && !hit_ex1;
      end
    end
  end

  wd_state_t      wd_state;
  logic [CW-1:0]  wait_cnt, cnt_inc;

  assign cnt_inc = wait_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_state <= RUN;
      wait_cnt <= '0;
      dm_err   <= 1'b0;
    end else begin
      case (wd_state)
        RUN: if (dm_busy) begin
          wd_state <= MEM_WAIT;
          wait_cnt <= CW'(1);
        end
        MEM_WAIT: if (!dm_busy) begin
          wd_state <= RUN;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= cnt_inc;
          if (cnt_inc > CW'(DM_TIMEOUT)) begin
            wd_state <= ERR;
            dm_err   <= 1'b1;
          end
        end
        ERR:     dm_err   <= 1'b1;
        default: wd_state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic ldu_take;
  assign ldu_take = ldu && !dm_busy && !br_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldu_cnt <= '0;
      mem_cnt <= '0;
    end else begin
      if (ldu_take && ldu_cnt != 16'hFFFF) ldu_cnt <= ldu_cnt + 16'd1;
      if (dm_busy && mem_cnt != 16'hFFFF)  mem_cnt <= mem_cnt + 16'd1;
    end
  end
`else
  assign ldu_cnt = '0;
  assign mem_cnt = '0;
`endif

endmodule
